alu_exec_fsm: RTL and testbench
===============================

Name: alu_exec_fsm

Overview:
Execute-stage sequencer for register-register ALU instructions (ADD, SUB, NOT, AND, OR, XOR, XNOR).
- Sits directly downstream of the instruction fetch/decode FSM.
- Consumes its 4-bit dispatch code, its IR-load strobe and the latched IR fields.
- Drives register-file bus enables, ALU operand/result latches and the ALU op select, then returns DONE so fetch can issue the next instruction.

Parameters:
NUM_REGS, 16, number of general registers; width of the one-hot enable vectors.
REG_SEL_W, 4, width of the rd/rs1/rs2 fields; NUM_REGS = 2**REG_SEL_W.
EXEC_CODE, 4'b0001, FSM_start value that dispatches this block.
DONE_HOLD, 3, cycles DONE stays high; min 3 so fetch sees it in both its wait state and its idle state.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
FSM_start  input  4  dispatch code from fetch; level, held until fetch's next dispatch
IR_in_en  input  1  fetch's IR load strobe; re-arms this block
ir  input  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
reg_out_en  output  NUM_REGS  one-hot register-to-bus enable
reg_in_en  output  NUM_REGS  one-hot bus-to-register enable
A_in_en  output  1  ALU operand-A latch enable
G_in_en  output  1  ALU result (G) latch enable
G_out_en  output  1  G-to-bus enable
alu_op  output  3  ADD 000, SUB 001, NOT 010, AND 011, OR 100, XOR 101, XNOR 110
DONE  output  1  completion to fetch
illegal_op  output  1  sticky; set on dispatch with a non-ALU opcode

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clock.
- Reset values: all outputs 0, alu_op 000, armed 0, state IDLE.
- Reset mid-operation aborts; the next edge returns all outputs to 0.
- Arming:
  - armed sets on any cycle with IR_in_en=1.
  - armed clears on accept.
  - Because FSM_start is a held level, back-to-back ALU instructions are distinguished only by re-arm.
- Accept: in IDLE, when armed && FSM_start==EXEC_CODE.
  - On accept, latch opcode, rd, rs1 and rs2 into internal registers.
  - All later decoding uses the latched copies.
  - ir and FSM_start changes are ignored until IDLE.
- Outputs are Moore, decoded from the state register. Cycle 0 is the accept cycle.
  - S_A (cycle 1): reg_out_en[rs1]=1, A_in_en=1.
  - S_B (cycle 2): reg_out_en[rs2]=1 (suppressed for NOT), G_in_en=1.
  - S_C (cycle 3): G_out_en=1, reg_in_en[rd]=1.
  - S_DONE (cycles 4..3+DONE_HOLD): DONE=1; internal down-counter.
  - Then IDLE.
- alu_op is valid from S_A through S_C and is 000 otherwise.
- Opcode map: 0001-0111 map to alu_op 000-110.
- Illegal opcode at accept: go straight to S_DONE with no bus or latch enables, and set illegal_op (cleared only by reset).
- Bus invariants:
  - At most one reg_out_en bit is high.
  - reg_out_en and G_out_en are never high together.
  - reg_in_en is high only in S_C.
- rd==rs1 or rd==rs2 is legal; no special handling.
- IR_in_en during a busy state only sets armed. It does not start a new operation until IDLE.

Optional Feature:
ALU_FLAGS_EN.
- Defined: adds output flags_in_en (1 bit), high in S_B together with G_in_en, so the flag register captures Z/N/C of the ALU result. It is never high for illegal opcodes.
- Undefined: the port is absent and all other timing is identical.

Decomposition:
- Shared package ssm_pkg holds:
  - the opcode constants;
  - the FSM_start dispatch codes (EXEC_CODE among them);
  - the alu_op encoding;
  - the exec state enum.
- One sub-module, reg_sel_decoder: REG_SEL_W-bit index plus enable in, one-hot NUM_REGS out. It is instantiated twice, once for reg_out_en and once for reg_in_en.

Test Plan:
- ADD: IR_in_en pulse, then ir=16'h1312, FSM_start=0001 → cycle 1: reg_out_en=16'h0002, A_in_en; cycle 2: reg_out_en=16'h0004, G_in_en, alu_op=000; cycle 3: G_out_en, reg_in_en=16'h0008; DONE high cycles 4-6.
- NOT: ir=16'h3250 → S_B has reg_out_en=0 and G_in_en=1, alu_op=010; rd=2 is written in S_C.
- Back-to-back ALU instructions with FSM_start held at 0001 → no second accept until IR_in_en pulses; after the pulse, a second full sequence runs.
- FSM_start=0010, or 0001 without armed → no output activity; DONE stays 0.
- Illegal opcode (ir=16'hF000, FSM_start=0001, armed) → no enables, DONE for 3 cycles, illegal_op=1 until reset.
- Reset asserted in S_B → next edge: all outputs 0, state IDLE; a fresh IR_in_en plus dispatch completes normally.

Source files
------------

// File: rtl/ssm_pkg.sv
// Shared definitions for the instruction sequencer slice: opcodes,
// dispatch codes, the ALU op-select encoding and the execute FSM states.
package ssm_pkg;

    // Instruction opcodes (ir[15:12]) for register-register ALU operations
    localparam logic [3:0] OPC_ADD  = 4'b0001;
    localparam logic [3:0] OPC_SUB  = 4'b0010;
    localparam logic [3:0] OPC_NOT  = 4'b0011;
    localparam logic [3:0] OPC_AND  = 4'b0100;
    localparam logic [3:0] OPC_OR   = 4'b0101;
    localparam logic [3:0] OPC_XOR  = 4'b0110;
    localparam logic [3:0] OPC_XNOR = 4'b0111;

    // FSM_start dispatch codes issued by fetch/decode
    localparam logic [3:0] DISPATCH_NONE = 4'b0000;
    localparam logic [3:0] DISPATCH_ALU  = 4'b0001;
    localparam logic [3:0] DISPATCH_MEM  = 4'b0010;

    // ALU op-select encoding
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_NOT  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_XNOR = 3'b110
    } alu_op_t;

    // Execute FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_C    = 3'd3,
        S_DONE = 3'd4
    } exec_state_t;

    // True for opcodes this block executes
    function automatic logic opcode_is_alu(input logic [3:0] opc);
        return (opc >= OPC_ADD) && (opc <= OPC_XNOR);
    endfunction

    // Opcodes 0001..0111 map directly onto alu_op 000..110
    function automatic alu_op_t opcode_to_alu_op(input logic [3:0] opc);
        return alu_op_t'(opc[2:0] - 3'd1);
    endfunction

endpackage

// File: rtl/alu_exec_fsm_if.sv
// Fetch-to-execute connection plus the datapath control bus driven by the
// execute sequencer. Optional macro: ALU_FLAGS_EN adds flags_in_en.
//
// Handshake: fetch loads a new IR with a one-cycle IR_in_en strobe, which
// arms the sequencer, and holds FSM_start as a level. The sequencer accepts
// when it is IDLE, armed, and FSM_start equals its dispatch code; it then
// ignores FSM_start and ir until it returns to IDLE, and signals completion
// by holding DONE high for DONE_HOLD cycles.
interface alu_exec_fsm_if #(
    parameter int NUM_REGS = 16
);
    logic [3:0]          FSM_start;
    logic                IR_in_en;
    logic [15:0]         ir;
    logic [NUM_REGS-1:0] reg_out_en;
    logic [NUM_REGS-1:0] reg_in_en;
    logic                A_in_en;
    logic                G_in_en;
    logic                G_out_en;
    logic [2:0]          alu_op;
    logic                DONE;
    logic                illegal_op;
`ifdef ALU_FLAGS_EN
    logic                flags_in_en;

    modport master (
        output FSM_start, IR_in_en, ir,
        input  reg_out_en, reg_in_en, A_in_en, G_in_en, G_out_en,
        input  alu_op, DONE, illegal_op, flags_in_en
    );
    modport slave (
        input  FSM_start, IR_in_en, ir,
        output reg_out_en, reg_in_en, A_in_en, G_in_en, G_out_en,
        output alu_op, DONE, illegal_op, flags_in_en
    );
`else
    modport master (
        output FSM_start, IR_in_en, ir,
        input  reg_out_en, reg_in_en, A_in_en, G_in_en, G_out_en,
        input  alu_op, DONE, illegal_op
    );
    modport slave (
        input  FSM_start, IR_in_en, ir,
        output reg_out_en, reg_in_en, A_in_en, G_in_en, G_out_en,
        output alu_op, DONE, illegal_op
    );
`endif
endinterface

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot bus enable decoder; all zeros when disabled.
module reg_sel_decoder #(
    parameter int REG_SEL_W = 4,
    parameter int NUM_REGS  = 2**REG_SEL_W
) (
    input  logic [REG_SEL_W-1:0] sel,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  onehot
);

    // Single enable bit at the selected index
    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/alu_exec_fsm.sv
// Execute-stage sequencer for register-register ALU instructions.
// Optional macro: ALU_FLAGS_EN drives flags_in_en alongside G_in_en.
module alu_exec_fsm
    import ssm_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter int         REG_SEL_W = 4,
    parameter logic [3:0] EXEC_CODE = DISPATCH_ALU,
    parameter int         DONE_HOLD = 3
) (
    input  logic          clock,
    input  logic          reset,
    alu_exec_fsm_if.slave bus,
    output exec_state_t   state_dbg
);

    localparam int CNT_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

    exec_state_t          state, state_nx;
    logic                 armed;
    logic                 accept;
    logic                 illegal_q;
    logic [3:0]           opc_q;
    logic [REG_SEL_W-1:0] rd_q, rs1_q, rs2_q;
    logic [CNT_W-1:0]     cnt;

    logic                 oe_en, ie_en;
    logic [REG_SEL_W-1:0] oe_sel;

    assign accept = (state == S_IDLE) && armed && (bus.FSM_start == EXEC_CODE);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Arm flag, latched IR fields, sticky illegal flag and DONE hold counter
    always_ff @(posedge clock) begin
        if (reset) begin
            armed     <= 1'b0;
            illegal_q <= 1'b0;
            opc_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            cnt       <= '0;
        end else begin
            // A new IR load wins over a same-cycle accept so it is not lost
            if (bus.IR_in_en)  armed <= 1'b1;
            else if (accept)   armed <= 1'b0;
            if (accept) begin
                opc_q <= bus.ir[15:12];
                rd_q  <= bus.ir[8 +: REG_SEL_W];
                rs1_q <= bus.ir[4 +: REG_SEL_W];
                rs2_q <= bus.ir[0 +: REG_SEL_W];
                if (!opcode_is_alu(bus.ir[15:12])) illegal_q <= 1'b1;
            end
            if (state_nx == S_DONE && state != S_DONE) cnt <= CNT_W'(DONE_HOLD - 1);
            else if (state == S_DONE && cnt != '0)     cnt <= cnt - 1'b1;
        end
    end

    // Next-state: fixed A/B/C sequence, illegal opcodes skip straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = opcode_is_alu(bus.ir[15:12]) ? S_A : S_DONE;
            S_A:    state_nx = S_B;
            S_B:    state_nx = S_C;
            S_C:    state_nx = S_DONE;
            S_DONE: if (cnt == '0) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register and latched fields
    always_comb begin
        oe_en        = 1'b0;
        oe_sel       = rs1_q;
        ie_en        = 1'b0;
        bus.A_in_en  = 1'b0;
        bus.G_in_en  = 1'b0;
        bus.G_out_en = 1'b0;
        bus.DONE     = 1'b0;
        bus.alu_op   = ALU_ADD;
`ifdef ALU_FLAGS_EN
        bus.flags_in_en = 1'b0;
`endif
        case (state)
            S_A: begin
                oe_en       = 1'b1;
                oe_sel      = rs1_q;
                bus.A_in_en = 1'b1;
                bus.alu_op  = opcode_to_alu_op(opc_q);
            end
            S_B: begin
                // NOT is unary: operand B is never placed on the bus
                oe_en       = (opc_q != OPC_NOT);
                oe_sel      = rs2_q;
                bus.G_in_en = 1'b1;
                bus.alu_op  = opcode_to_alu_op(opc_q);
`ifdef ALU_FLAGS_EN
                bus.flags_in_en = 1'b1;
`endif
            end
            S_C: begin
                ie_en        = 1'b1;
                bus.G_out_en = 1'b1;
                bus.alu_op   = opcode_to_alu_op(opc_q);
            end
            S_DONE:  bus.DONE = 1'b1;
            default: ;
        endcase
    end

    assign bus.illegal_op = illegal_q;
    assign state_dbg      = state;

    reg_sel_decoder #(.REG_SEL_W(REG_SEL_W), .NUM_REGS(NUM_REGS)) u_out_dec (
        .sel    (oe_sel),
        .en     (oe_en),
        .onehot (bus.reg_out_en)
    );

    reg_sel_decoder #(.REG_SEL_W(REG_SEL_W), .NUM_REGS(NUM_REGS)) u_in_dec (
        .sel    (rd_q),
        .en     (ie_en),
        .onehot (bus.reg_in_en)
    );

endmodule

// File: tb/tb_alu_exec_fsm.sv
// Directed self-checking bench for the ALU execute sequencer.
module tb_alu_exec_fsm;
    import ssm_pkg::*;

    logic        clock;
    logic        reset;
    exec_state_t state_dbg;
    int          checks;
    int          errors;
    logic        mon_en;

    alu_exec_fsm_if #(.NUM_REGS(16)) bus ();

    alu_exec_fsm dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_oe"}, 32'(bus.reg_out_en), 32'h0);
        check({tag, "_ie"}, 32'(bus.reg_in_en), 32'h0);
        check({tag, "_ctl"}, {29'd0, bus.A_in_en, bus.G_in_en, bus.G_out_en}, 32'h0);
        check({tag, "_op"}, 32'(bus.alu_op), 32'h0);
        check({tag, "_done"}, 32'(bus.DONE), 32'h0);
    endtask

    // Arm, accept and walk one full legal instruction
    task automatic run_alu(input string tag, input logic [15:0] ir_val,
                           input logic [15:0] a_oe, input logic [15:0] b_oe,
                           input logic [15:0] ie, input logic [2:0] op);
        bus.ir        = ir_val;
        bus.FSM_start = DISPATCH_ALU;
        bus.IR_in_en  = 1'b1;
        step();
        bus.IR_in_en  = 1'b0;
        check({tag, "_c0_state"}, 32'(state_dbg), 32'(S_IDLE));
        step();
        check({tag, "_a_state"}, 32'(state_dbg), 32'(S_A));
        check({tag, "_a_oe"}, 32'(bus.reg_out_en), 32'(a_oe));
        check({tag, "_a_ctl"}, {29'd0, bus.A_in_en, bus.G_in_en, bus.G_out_en}, 32'b100);
        check({tag, "_a_op"}, 32'(bus.alu_op), 32'(op));
        step();
        check({tag, "_b_oe"}, 32'(bus.reg_out_en), 32'(b_oe));
        check({tag, "_b_ctl"}, {29'd0, bus.A_in_en, bus.G_in_en, bus.G_out_en}, 32'b010);
        check({tag, "_b_op"}, 32'(bus.alu_op), 32'(op));
`ifdef ALU_FLAGS_EN
        check({tag, "_b_flags"}, 32'(bus.flags_in_en), 32'h1);
`endif
        step();
        check({tag, "_c_oe"}, 32'(bus.reg_out_en), 32'h0);
        check({tag, "_c_ie"}, 32'(bus.reg_in_en), 32'(ie));
        check({tag, "_c_ctl"}, {29'd0, bus.A_in_en, bus.G_in_en, bus.G_out_en}, 32'b001);
        check({tag, "_c_op"}, 32'(bus.alu_op), 32'(op));
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, "_done_hi"}, 32'(bus.DONE), 32'h1);
            check({tag, "_done_ie"}, 32'(bus.reg_in_en), 32'h0);
            check({tag, "_done_op"}, 32'(bus.alu_op), 32'h0);
        end
        step();
        check({tag, "_end_state"}, 32'(state_dbg), 32'(S_IDLE));
        check({tag, "_end_done"}, 32'(bus.DONE), 32'h0);
    endtask

    // Bus invariants sampled on the falling edge every cycle
    always @(negedge clock) begin
        if (mon_en) begin
            check("inv_oe_onehot", 32'($countones(bus.reg_out_en) <= 1), 32'h1);
            check("inv_oe_vs_g", 32'((bus.reg_out_en != 0) && bus.G_out_en), 32'h0);
            check("inv_ie_only_c", 32'((bus.reg_in_en != 0) && (state_dbg != S_C)), 32'h0);
`ifdef ALU_FLAGS_EN
            check("inv_flags_g", 32'(bus.flags_in_en), 32'(bus.G_in_en));
`endif
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        mon_en        = 1'b0;
        reset         = 1'b1;
        bus.FSM_start = DISPATCH_NONE;
        bus.IR_in_en  = 1'b0;
        bus.ir        = 16'h0000;
        step();
        step();
        mon_en = 1'b1;
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check_quiet("rst");
        check("rst_illegal", 32'(bus.illegal_op), 32'h0);
        reset = 1'b0;
        step();

        // ADD r3 <- r1 + r2
        run_alu("add", 16'h1312, 16'h0002, 16'h0004, 16'h0008, 3'b000);

        // FSM_start still held at ALU dispatch, not re-armed: nothing starts
        for (int i = 0; i < 4; i++) begin
            step();
            check("noarm_state", 32'(state_dbg), 32'(S_IDLE));
            check_quiet("noarm");
        end

        // Back-to-back instruction after a fresh IR load: NOT r2 <- ~r5
        run_alu("not", 16'h3250, 16'h0020, 16'h0000, 16'h0004, 3'b010);
        run_alu("sub", 16'h2A9B, 16'h0200, 16'h0800, 16'h0400, 3'b001);
        run_alu("xnor", 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 3'b110);
        run_alu("xor", 16'h6001, 16'h0001, 16'h0002, 16'h0001, 3'b101);

        // Armed but dispatched to another unit: nothing starts
        bus.ir        = 16'h1111;
        bus.FSM_start = DISPATCH_MEM;
        bus.IR_in_en  = 1'b1;
        step();
        bus.IR_in_en  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("otherdisp_state", 32'(state_dbg), 32'(S_IDLE));
            check_quiet("otherdisp");
        end

        // Still armed: switching dispatch to ALU with an illegal opcode
        bus.ir        = 16'hF000;
        bus.FSM_start = DISPATCH_ALU;
        step();
        for (int i = 0; i < 3; i++) begin
            check("ill_state", 32'(state_dbg), 32'(S_DONE));
            check("ill_done", 32'(bus.DONE), 32'h1);
            check("ill_oe", 32'(bus.reg_out_en), 32'h0);
            check("ill_ctl", {29'd0, bus.A_in_en, bus.G_in_en, bus.G_out_en}, 32'h0);
            check("ill_flag", 32'(bus.illegal_op), 32'h1);
            step();
        end
        check("ill_end_state", 32'(state_dbg), 32'(S_IDLE));
        check("ill_end_done", 32'(bus.DONE), 32'h0);
        check("ill_sticky", 32'(bus.illegal_op), 32'h1);
        step();
        check("ill_sticky2", 32'(bus.illegal_op), 32'h1);
        check("ill_noreaccept", 32'(state_dbg), 32'(S_IDLE));

        // Reset while in S_B aborts the AND instruction
        bus.ir        = 16'h4ABC;
        bus.IR_in_en  = 1'b1;
        step();
        bus.IR_in_en  = 1'b0;
        step();
        step();
        check("abort_in_b", 32'(state_dbg), 32'(S_B));
        check("abort_b_op", 32'(bus.alu_op), 32'(ALU_AND));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_state", 32'(state_dbg), 32'(S_IDLE));
        check_quiet("abort");
        check("abort_illegal", 32'(bus.illegal_op), 32'h0);
        step();
        check("abort_noarm", 32'(state_dbg), 32'(S_IDLE));

        // Fresh instruction after the abort: OR r1 <- r2 | r3
        run_alu("or", 16'h5123, 16'h0004, 16'h0008, 16'h0002, 3'b100);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
